// File: rtl/alu_operand_loader.sv
// Sequential front end for the 3-bit ALU: debounces the enter button, steps through
// operand a, operand b and op select entry, then captures the ALU result.
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int OPW             = 3,
    parameter int RESW            = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  sw,
    input  logic            btn_enter,
    input  logic [RESW-1:0] alu_q,
    output logic [OPW-1:0]  alu_a,
    output logic [OPW-1:0]  alu_b,
    output logic [1:0]      alu_sel,
    output logic [RESW-1:0] result,
    output logic            result_valid,
    output logic [1:0]      state_code
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LD_A  = 2'b00,
        LD_B  = 2'b01,
        LD_OP = 2'b10,
        EXEC  = 2'b11
    } state_t;

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic             enter_p;

    state_t           state_q, state_d;
    logic [OPW-1:0]   alu_a_q, alu_a_d;
    logic [OPW-1:0]   alu_b_q, alu_b_d;
    logic [1:0]       alu_sel_q, alu_sel_d;
    logic [RESW-1:0]  result_q, result_d;
    logic             result_valid_q, result_valid_d;

    // The level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign enter_p = stable_q & ~stable_dly_q;

    always_comb begin
        state_d        = state_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_sel_d      = alu_sel_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        case (state_q)
            LD_A: begin
                if (enter_p) begin
                    alu_a_d        = sw;
                    result_valid_d = 1'b0;
                    state_d        = LD_B;
                end
            end
            LD_B: begin
                if (enter_p) begin
                    alu_b_d = sw;
                    state_d = LD_OP;
                end
            end
            LD_OP: begin
                if (enter_p) begin
                    alu_sel_d = sw[1:0];
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                result_d       = alu_q;
                result_valid_d = 1'b1;
                state_d        = LD_A;
            end
            default: state_d = LD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            cnt_q          <= '0;
            stable_q       <= 1'b0;
            stable_dly_q   <= 1'b0;
            state_q        <= LD_A;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_sel_q      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            sync1_q        <= btn_enter;
            sync2_q        <= sync1_q;
            cnt_q          <= cnt_d;
            stable_q       <= stable_d;
            stable_dly_q   <= stable_q;
            state_q        <= state_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_sel_q      <= alu_sel_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_sel      = alu_sel_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign state_code   = state_q;

endmodule
